// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: mode encoding, rate table and pad constants.
package sha3_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 7;

  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
  localparam logic [7:0] FINAL_BIT   = 8'h80;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } pad_state_e;

  // Rate of each variant in 16-bit words (rate bits / 16).
  function automatic logic [CNT_W-1:0] rate_words(input sha3_mode_e mode);
    logic [CNT_W-1:0] words;
    case (mode)
      SHA3_224: words = CNT_W'(72);
      SHA3_256: words = CNT_W'(68);
      SHA3_384: words = CNT_W'(52);
      default:  words = CNT_W'(36);
    endcase
    return words;
  endfunction

  // Index of the last word in a rate block.
  function automatic logic [CNT_W-1:0] last_word_idx(input sha3_mode_e mode);
    return rate_words(mode) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/sha3_pad_stream.sv
// SHA-3 input stage: applies FIPS 202 padding to a byte-granular 16-bit
// stream and emits words cut into rate-sized blocks.
module sha3_pad_stream
  import sha3_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic [1:0]       s_tkeep,
  input  logic             s_tlast,
  input  logic [1:0]       s_tuser,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tblock_end,
  output logic             m_tlast,
  output logic [1:0]       m_tuser
);

  pad_state_e       r_state;
  pad_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pend06;
  logic             w_pend06_nxt;
  logic             r_in_msg;
  logic             w_in_msg_nxt;
  sha3_mode_e       r_mode;
  sha3_mode_e       w_mode_nxt;

  sha3_mode_e       w_mode;
  logic             w_at_end;
  logic [7:0]       w_fin;
  logic             w_load_ok;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_word;
  logic             w_word_last;

  // Mode in effect: live s_tuser on the first beat, latched value afterwards.
  assign w_mode    = (r_state == ST_PASS && !r_in_msg) ? sha3_mode_e'(s_tuser) : r_mode;
  assign w_at_end  = (r_cnt == last_word_idx(w_mode));
  assign w_fin     = w_at_end ? FINAL_BIT : 8'h00;
  assign w_load_ok = !m_tvalid || m_tready;
  assign s_tready  = (r_state == ST_PASS) && w_load_ok;
  assign w_accept  = s_tvalid && s_tready;

  // State register and per-message bookkeeping.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= ST_PASS;
      r_cnt    <= '0;
      r_pend06 <= 1'b0;
      r_in_msg <= 1'b0;
      r_mode   <= SHA3_224;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend06 <= w_pend06_nxt;
      r_in_msg <= w_in_msg_nxt;
      r_mode   <= w_mode_nxt;
    end
  end

  // Next state and the word to load into the output register.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend06_nxt = r_pend06;
    w_in_msg_nxt = r_in_msg;
    w_mode_nxt   = r_mode;
    w_load       = 1'b0;
    w_word       = '0;
    w_word_last  = 1'b0;

    unique case (r_state)
      ST_PASS: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_in_msg_nxt = !s_tlast;
          if (!r_in_msg) begin
            w_mode_nxt = sha3_mode_e'(s_tuser);
          end
          if (!s_tlast) begin
            // Partial keep on a non-last beat is taken as a full beat.
            w_word = s_tdata;
          end else begin
            case (s_tkeep)
              2'b01: begin
                w_word = {DOMAIN_BYTE | w_fin, s_tdata[7:0]};
                if (w_at_end) begin
                  w_word_last = 1'b1;
                end else begin
                  w_state_nxt  = ST_PAD;
                  w_pend06_nxt = 1'b0;
                end
              end
              2'b00: begin
                w_word = {w_fin, DOMAIN_BYTE};
                if (w_at_end) begin
                  w_word_last = 1'b1;
                end else begin
                  w_state_nxt  = ST_PAD;
                  w_pend06_nxt = 1'b0;
                end
              end
              default: begin
                // Full final word: domain byte goes into the next pad word.
                w_word       = s_tdata;
                w_state_nxt  = ST_PAD;
                w_pend06_nxt = 1'b1;
              end
            endcase
          end
        end
      end
      ST_PAD: begin
        if (w_load_ok) begin
          w_load       = 1'b1;
          w_word       = {w_fin, r_pend06 ? DOMAIN_BYTE : 8'h00};
          w_pend06_nxt = 1'b0;
          if (w_at_end) begin
            w_word_last = 1'b1;
            w_state_nxt = ST_PASS;
          end
        end
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase

    // Word index advances with every loaded word and wraps at block end.
    if (w_load) begin
      w_cnt_nxt = w_at_end ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Output register: loads a new word or holds it while stalled.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      m_tlast      <= 1'b0;
      m_tblock_end <= 1'b0;
      m_tuser      <= 2'd0;
    end else if (w_load) begin
      m_tvalid     <= 1'b1;
      m_tdata      <= w_word;
      m_tlast      <= w_word_last;
      m_tblock_end <= w_at_end;
      m_tuser      <= w_mode;
    end else if (m_tready) begin
      m_tvalid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha3_pad_stream.sv
// Scoreboard bench for sha3_pad_stream: directed messages, stalls and reset.
module tb_sha3_pad_stream;

  localparam int unsigned WIDTH = 16;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b1;
  logic [WIDTH-1:0] s_tdata = '0;
  logic [1:0]       s_tkeep = 2'b00;
  logic             s_tlast = 1'b0;
  logic [1:0]       s_tuser = 2'd0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tblock_end;
  logic             m_tlast;
  logic [1:0]       m_tuser;

  sha3_pad_stream #(.WIDTH(WIDTH)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tblock_end(m_tblock_end),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        blk;
    logic [1:0]  user;
  } exp_t;

  exp_t         exp_q[$];
  byte unsigned msg[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           force_low = 1'b0;
  bit           stall_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int rate_bytes(input logic [1:0] m);
    case (m)
      2'd0:    return 144;
      2'd1:    return 136;
      2'd2:    return 104;
      default: return 72;
    endcase
  endfunction

  task automatic push_word(input logic [15:0] d, input logic l, input logic b, input logic [1:0] u);
    exp_t e;
    e.data = d; e.last = l; e.blk = b; e.user = u;
    exp_q.push_back(e);
  endtask

  // Byte-level reference padding: msg || 0x06 || 0* , last byte |= 0x80.
  task automatic push_model(input logic [1:0] mode);
    byte unsigned p[$];
    int rb;
    int nw;
    rb = rate_bytes(mode);
    p = msg;
    p.push_back(8'h06);
    while ((p.size() % rb) != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nw = p.size() / 2;
    for (int w = 0; w < nw; w++) begin
      push_word({p[2*w+1], p[2*w]}, (w == nw - 1), (((w + 1) % (rb / 2)) == 0), mode);
    end
  endtask

  // Hand-written expectation for an empty or "abc"-style mode-1 message.
  task automatic push_short_mode1(input logic [15:0] w0, input logic has_w1, input logic [15:0] w1);
    int nz;
    push_word(w0, 1'b0, 1'b0, 2'd1);
    if (has_w1) push_word(w1, 1'b0, 1'b0, 2'd1);
    nz = has_w1 ? 65 : 66;
    for (int i = 0; i < nz; i++) push_word(16'h0000, 1'b0, 1'b0, 2'd1);
    push_word(16'h8000, 1'b1, 1'b1, 2'd1);
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic [1:0] k, input logic l, input logic [1:0] u);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge ACLK);
      if (s_tready) begin
        @(posedge ACLK);
        #1;
        s_tvalid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL beat_timeout: got no s_tready expected acceptance within 2000 cycles");
    s_tvalid = 1'b0;
  endtask

  task automatic send_msg(input logic [1:0] mode, input bit empty_tail, input bit wild_user);
    int n;
    int nb;
    logic [1:0] u;
    n = msg.size();
    nb = (n + 1) / 2;
    if (n == 0) begin
      drive_beat(16'h0000, 2'b00, 1'b1, mode);
    end else begin
      for (int i = 0; i < nb; i++) begin
        u = (wild_user && i > 0) ? 2'($urandom) : mode;
        if (2 * i + 1 < n)
          drive_beat({msg[2*i+1], msg[2*i]}, 2'b11, (i == nb - 1) && !empty_tail, u);
        else
          drive_beat({8'h00, msg[2*i]}, 2'b01, 1'b1, u);
      end
      if (empty_tail) drive_beat(16'h0000, 2'b00, 1'b1, wild_user ? 2'($urandom) : mode);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(posedge ACLK);
    repeat (3) @(posedge ACLK);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_msg(input int n, input int seed);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'((i * 7 + seed) & 8'hff));
  endtask

  // Downstream ready: forced low, random, or held high.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      if (force_low)     m_tready = 1'b0;
      else if (stall_en) m_tready = 1'($urandom_range(0, 1));
      else               m_tready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability.
  initial begin
    exp_t got;
    exp_t want;
    exp_t held;
    bit   stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        stalled = 1'b0;
        continue;
      end
      got.data = m_tdata; got.last = m_tlast; got.blk = m_tblock_end; got.user = m_tuser;
      if (stalled) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_hold", 32'(got), 32'(held));
      end
      stalled = m_tvalid && !m_tready;
      held = got;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no word", got);
        end else begin
          want = exp_q.pop_front();
          check("out_word", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tblock_end", 32'(m_tblock_end), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd1);

    // Empty message, mode 1.
    msg.delete();
    push_short_mode1(16'h0006, 1'b0, 16'h0000);
    send_msg(2'd1, 1'b0, 1'b0);
    drain("drain_empty_msg");

    // "abc", mode 1.
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    push_short_mode1(16'h6261, 1'b1, 16'h0663);
    send_msg(2'd1, 1'b0, 1'b0);
    drain("drain_abc");

    // 67 full words, mode 1: domain and final bit share word 67.
    fill_msg(134, 3);
    push_model(2'd1);
    send_msg(2'd1, 1'b0, 1'b0);
    drain("drain_67w");

    // 36 full words, mode 3: a whole extra pad block.
    fill_msg(72, 11);
    push_model(2'd3);
    send_msg(2'd3, 1'b0, 1'b0);
    drain("drain_36w");

    // Odd byte lands on the last word of the block: 0x86 in the high byte.
    fill_msg(71, 5);
    push_model(2'd3);
    send_msg(2'd3, 1'b0, 1'b0);
    drain("drain_keep01_end");

    // Empty last beat landing on the block end: 0x8006.
    fill_msg(70, 9);
    push_model(2'd3);
    send_msg(2'd3, 1'b1, 1'b0);
    drain("drain_keep00_end");

    // Mode 2 short odd message.
    fill_msg(5, 1);
    push_model(2'd2);
    send_msg(2'd2, 1'b0, 1'b0);
    drain("drain_mode2");

    // 300 bytes, mode 0, random stalls and ignored mid-message s_tuser.
    stall_en = 1'b1;
    fill_msg(300, 17);
    push_model(2'd0);
    send_msg(2'd0, 1'b0, 1'b1);
    drain("drain_stall");
    stall_en = 1'b0;

    // Reset in the middle of PAD, then "abc" again.
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    push_short_mode1(16'h6261, 1'b1, 16'h0663);
    send_msg(2'd1, 1'b0, 1'b0);
    repeat (10) @(posedge ACLK);
    #1;
    force_low = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    exp_q.delete();
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("post_rst_tlast", 32'(m_tlast), 32'd0);
    check("post_rst_tready", 32'(s_tready), 32'd1);
    @(posedge ACLK);
    #1;
    check("post_rst_idle", 32'(m_tvalid), 32'd0);
    force_low = 1'b0;
    push_short_mode1(16'h6261, 1'b1, 16'h0663);
    send_msg(2'd1, 1'b0, 1'b0);
    drain("drain_abc_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
